measure_sequencer: RTL

//  Sequenced controller for the cursor-measurement path of the N-channel scope.
//  On a button edge or periodic auto tick it snapshots the cursor/scale inputs for the selected wave.
//  It forms |cursor delta| and runs a shared sequential multiplier, then saturates the result.
//  It publishes a 14-bit value to the seven-segment driver with a valid pulse and busy flag.

---
 rtl/measure_pkg.sv | 27 ++
 rtl/measure_sequencer_mult.sv | 49 ++++
 rtl/measure_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/measure_pkg.sv
// Shared types and constants for the cursor-measurement sequencer.
package measure_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    MULT,
    DONE
  } state_t;

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_X    = 3'd1;
  localparam logic [2:0] MODE_Y    = 3'd2;

  localparam int RESULT_MAX  = 9999;
  localparam int RESULT_RST  = 6;
  localparam int MULT_CYCLES = 8;

  // Compare first so the subtraction can never wrap.
  function automatic logic [10:0] abs_delta(
    input logic [10:0] a,
    input logic [10:0] b
  );
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/measure_sequencer_mult.sv
// Fixed-latency shift-add multiplier shared by both measurement modes.
module shift_add_mult
  import measure_pkg::*;
#(
  parameter int A_W = 11,
  parameter int B_W = 8,
  parameter int P_W = 19
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic           done,
  output logic [P_W-1:0] product
);

  logic [P_W-1:0] mcand;
  logic [B_W-1:0] mplier;
  logic [3:0]     cnt;
  logic           run;

  // Bit 0 is folded into the load so the last bit lands on cycle 8.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      product <= '0;
    end else if (start) begin
      mcand   <= P_W'(a) << 1;
      mplier  <= b >> 1;
      cnt     <= 4'd1;
      run     <= 1'b1;
      product <= b[0] ? P_W'(a) : '0;
    end else if (run && cnt != 4'(MULT_CYCLES)) begin
      if (mplier[0]) product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 4'd1;
    end else if (run) begin
      run <= 1'b0;
    end
  end

  assign done = run && (cnt == 4'(MULT_CYCLES));

endmodule

// File: rtl/measure_sequencer.sv
// Button/auto-triggered cursor measurement: |delta| x scale, saturated
// to four display digits.
module measure_sequencer
  import measure_pkg::*;
#(
  parameter int CURSOR_W    = 11,
  parameter int RESULT_W    = 14,
  parameter int AUTO_PERIOD = 25_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                trigger,
  input  logic                auto_en,
  input  logic [1:0]          wave_sel,
  input  logic [2:0]          measure_mode,
  input  logic [CURSOR_W-1:0] cursor_x1,
  input  logic [CURSOR_W-1:0] cursor_x2,
  input  logic [CURSOR_W-1:0] cursor_y1,
  input  logic [CURSOR_W-1:0] cursor_y2,
  input  logic [5:0]          sample_adj1,
  input  logic [5:0]          sample_adj2,
  input  logic [3:0]          shift_down1,
  input  logic [3:0]          shift_down2,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic                busy,
  output logic                overflow
);

  localparam int CNT_W = $clog2(AUTO_PERIOD);

  state_t             state, state_next;
  logic               trig_s1, trig_s2, trig_d;
  logic               trig_edge, auto_tick, req;
  logic [CNT_W-1:0]   auto_cnt;
  logic               wave_q;
  logic               start;
  logic [10:0]        delta;
  logic [7:0]         operand;
  logic               mult_done;
  logic [18:0]        product;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
    end else begin
      trig_s1 <= trigger;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
    end
  end

  assign trig_edge = trig_s2 & ~trig_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      auto_cnt <= '0;
    else if (!auto_en || auto_tick)
      auto_cnt <= '0;
    else
      auto_cnt <= auto_cnt + 1'b1;
  end

  assign auto_tick = auto_en && (auto_cnt == CNT_W'(AUTO_PERIOD - 1));
  assign req       = trig_edge | auto_tick;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wave_q <= 1'b0;
    else if (state == IDLE) wave_q <= wave_sel[0];
  end

  // Mode none feeds a zero operand, which forces a zero product.
  always_comb begin
    delta   = '0;
    operand = '0;
    unique case (measure_mode)
      MODE_X: begin
        delta   = wave_q ? abs_delta(cursor_x1, cursor_x2)
                         : abs_delta(cursor_x1, cursor_x2);
        operand = wave_q ? 8'(sample_adj2) + 8'd1
                         : 8'(sample_adj1) + 8'd1;
      end
      MODE_Y: begin
        delta   = abs_delta(cursor_y1, cursor_y2);
        operand = wave_q ? 8'(shift_down2) * 8'(shift_down2)
                         : 8'(shift_down1) * 8'(shift_down1);
      end
      default: begin
        delta   = '0;
        operand = '0;
      end
    endcase
  end

  shift_add_mult #(
    .A_W(11),
    .B_W(8),
    .P_W(19)
  ) u_mult (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .a       (delta),
    .b       (operand),
    .done    (mult_done),
    .product (product)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE:    if (req && !wave_sel[1]) state_next = CAPTURE;
      CAPTURE: begin
        start      = 1'b1;
        state_next = MULT;
      end
      MULT:    if (mult_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result   <= RESULT_W'(RESULT_RST);
      overflow <= 1'b0;
    end else if (state == MULT && mult_done) begin
      overflow <= (product > 19'(RESULT_MAX));
      result   <= (product > 19'(RESULT_MAX)) ? RESULT_W'(RESULT_MAX)
                                               : product[RESULT_W-1:0];
    end
  end

  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);

endmodule
